tdm_demux16: RTL
================

Name: tdm_demux16

Overview:
- Receive-side counterpart of the 16:1 multiplexer: a 1-to-16 time-division demultiplexer and deserializer.
- Takes the serial stream a mux produces when its select is swept 0..15 and steers each bit to its lane.
- Assembles the 16 lanes into a parallel word and flags frame completion and resynchronisation errors.
- Sits after the serial link, feeding the parallel-word consumer.

Parameters:
- N_LANES, 16, number of lanes per frame; fixed at 16 for this revision.
- SEL_W, 4, slot counter width; must equal log2(N_LANES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is meaningful this cycle; bit is consumed only when high.
- frame_start  input  1  qualified by din_valid; the current bit belongs to slot 0.
- slot  output  SEL_W  slot index the next valid bit will be written to.
- lane_strobe  output  N_LANES  registered one-hot of the lane written last cycle; all zero if no write.
- word  output  N_LANES  last complete frame; bit i = bit received in slot i.
- word_valid  output  1  one-cycle pulse when word updates.
- sync_err  output  1  one-cycle pulse on resync mid-frame.

Behaviour:
- Reset (rst high at a clock edge):
  - slot=0, shadow register=0, word=16'h0000, word_valid=0, lane_strobe=0, sync_err=0.
  - rst takes priority over all inputs, including mid-frame. The partial frame is discarded and no word_valid is produced.
- Cycle with din_valid=0:
  - No state change except lane_strobe, word_valid and sync_err returning to 0.
- Cycle with din_valid=1 and frame_start=0:
  - shadow[slot] <= din.
  - lane_strobe <= one-hot(slot).
  - slot <= slot+1, wrapping 15->0 modulo 16.
- Cycle with din_valid=1 and frame_start=1:
  - Effective slot forced to 0: shadow[0] <= din, lane_strobe <= 16'h0001, slot <= 1.
  - If slot != 0 before this cycle, sync_err pulses 1 the next cycle and the partial frame is abandoned; stale shadow bits are overwritten as the new frame arrives.
  - frame_start with slot already 0 is a normal frame start with no error.
- Frame completion (valid bit accepted while effective slot==15):
  - word <= {din, shadow[14:0]}, all 16 bits updated at once.
  - word_valid pulses 1 in the following cycle, i.e. latency is one clock from the last bit.
  - word holds its value until the next completion or reset.
- frame_start is optional. Free-running streams frame purely by counter wrap.
- Back-to-back frames at full rate (din_valid held high): word_valid every 16 cycles, with no bubble required.
- frame_start with din_valid=0 is ignored.
- Combinational path limit: outputs are registered; din/din_valid/frame_start reach no output combinationally.

Decomposition:
- Shared package holds N_LANES, SEL_W and a one-hot decode function, reused by the mux-side sequencer.
- One natural sub-module, demux1to16: combinational 1-to-16 decoder producing a lane write-enable from slot and din_valid, mirroring the mux16to1 hierarchy.
- The top level holds the counter, shadow register, word register and pulse logic.

Test Plan:
- Reset then stream 16'h3f0a LSB first: frame_start on the first bit, din_valid=1 for 16 cycles. Expect word=16'h3f0a and word_valid one pulse the cycle after bit 15, slot=0, sync_err=0.
- Lane steering: same stream, check lane_strobe walks 16'h0001,16'h0002,...,16'h8000 one cycle behind each bit; slot reads 0..15 then 0.
- Gaps: stream 16'ha5c3 with din_valid low every other cycle. Expect word=16'ha5c3, a single word_valid, and slot frozen during gaps.
- Resync: send 7 bits, then frame_start with a full 16'h1234 frame. Expect sync_err pulse the cycle after frame_start, word=16'h1234, and no word_valid for the abandoned partial frame.
- Reset mid-frame: 10 bits of 16'hffff, rst for one cycle, then full frame 16'h00f0. Expect word=0 and all outputs 0 after reset, then word=16'h00f0 with exactly one word_valid.
- Continuous back-to-back frames 16'h3f0a then 16'hc0f5 without frame_start. Expect word_valid pulses exactly 16 cycles apart with matching words.

Source files
------------

// File: rtl/tdm_demux16_pkg.sv
// Shared constants and lane decode helper for the 16-lane TDM mux/demux pair.
// Used by both the receive-side demux and the mux-side sequencer.
package tdm_demux16_pkg;

    localparam int N_LANES = 16;
    localparam int SEL_W   = 4;

    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_LANES - 1);

    function automatic logic [N_LANES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_LANES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tdm_demux16_demux1to16.sv
// Combinational 1-to-16 lane decoder: one write-enable per lane.
// Mirrors the select decode of the transmit-side 16:1 mux.
module tdm_demux16_demux1to16
    import tdm_demux16_pkg::*;
(
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [N_LANES-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we = onehot(sel);
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// 1-to-16 TDM demultiplexer/deserializer: steers serial bits to lanes,
// publishes each completed frame as a parallel word, flags mid-frame resyncs.
module tdm_demux16
    import tdm_demux16_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               frame_start,
    output logic [SEL_W-1:0]   slot,
    output logic [N_LANES-1:0] lane_strobe,
    output logic [N_LANES-1:0] word,
    output logic               word_valid,
    output logic               sync_err
);

    logic [SEL_W-1:0]   slot_q, slot_d;
    logic [SEL_W-1:0]   eff_slot;
    logic [N_LANES-1:0] shadow_q, shadow_d;
    logic [N_LANES-1:0] word_q, word_d;
    logic [N_LANES-1:0] strobe_q, strobe_d;
    logic [N_LANES-1:0] lane_we;
    logic               word_valid_q, word_valid_d;
    logic               sync_err_q, sync_err_d;

    // frame_start pins the current bit to slot 0 regardless of the counter
    always_comb begin
        eff_slot = slot_q;
        if (frame_start) begin
            eff_slot = '0;
        end
    end

    tdm_demux16_demux1to16 u_demux (
        .sel (eff_slot),
        .en  (din_valid),
        .we  (lane_we)
    );

    always_comb begin
        slot_d       = slot_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        strobe_d     = lane_we;
        shadow_d     = (shadow_q & ~lane_we) | (lane_we & {N_LANES{din}});
        if (din_valid) begin
            slot_d     = eff_slot + SLOT_ONE;
            sync_err_d = frame_start && (slot_q != '0);
            if (eff_slot == SLOT_LAST) begin
                word_d       = {din, shadow_q[N_LANES-2:0]};
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            shadow_q     <= '0;
            word_q       <= '0;
            strobe_q     <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            word_q       <= word_d;
            strobe_q     <= strobe_d;
            word_valid_q <= word_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign slot        = slot_q;
    assign lane_strobe = strobe_q;
    assign word        = word_q;
    assign word_valid  = word_valid_q;
    assign sync_err    = sync_err_q;

endmodule
